// File: rtl/axi_bram_rd_ctrl.sv
// AXI4 read-channel slave feeding a synchronous-read boot BRAM, with a 2-entry R skid buffer.
// Define AXI_WRAP_BURST_EN to accept WRAP bursts (arlen 1/3/7/15); otherwise WRAP returns SLVERR.
module axi_bram_rd_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_AW = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic [7:0]        s_arlen,
   input  logic [2:0]        s_arsize,
   input  logic [1:0]        s_arburst,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [DATA_W-1:0] s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rlast,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_en,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int LB = $clog2(DATA_W/8);
   localparam int EW = DATA_W + 3;
`ifdef AXI_WRAP_BURST_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   typedef enum logic {IDLE, BURST} state_t;

   function automatic logic ar_error(input logic [ADDR_W-1:0] a, input logic [7:0] l,
                                     input logic [2:0] sz, input logic [1:0] b);
      logic e;
      logic wrap_ok;
      wrap_ok = (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15);
      e = (sz != 3'(LB)) || (b == 2'b11) || ((a >> (MEM_AW + LB)) != '0);
      if (b == 2'b10 && (!WRAP_EN || !wrap_ok)) e = 1'b1;
      return e;
   endfunction

   function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a,
                                                   input logic [1:0] b, input logic [7:0] l);
      logic [MEM_AW-1:0] inc;
      logic [MEM_AW-1:0] mask;
      logic [MEM_AW-1:0] nxt;
      inc  = a + 1'b1;
      mask = MEM_AW'(l);
      case (b)
         2'b00:   nxt = a;
         2'b10:   nxt = (a & ~mask) | (inc & mask);
         default: nxt = inc;
      endcase
      return nxt;
   endfunction

   state_t            state;
   logic [MEM_AW-1:0] waddr;
   logic [7:0]        len;
   logic [1:0]        burst;
   logic              err;
   logic [8:0]        issued;
   logic              req, req_last;
   logic              pend, pend_last, pend_err;
   logic [1:0]        occ;
   logic [EW-1:0]     b0, b1;

   logic              ar_hs, r_hs, has_buf, buf_pop, byp_pop, push, wr_hi, can_issue;
   logic              ar_err;
   logic [MEM_AW-1:0] ar_wa;
   logic [DATA_W-1:0] pend_data;
   logic [EW-1:0]     pend_ent, head;
   logic [2:0]        tot;

   assign ar_hs     = s_arvalid & s_arready;
   assign ar_err    = ar_error(s_araddr, s_arlen, s_arsize, s_arburst);
   assign ar_wa     = s_araddr[MEM_AW+LB-1:LB];

   // Stage boundary: BRAM data arriving this cycle, bypassed to R when the buffer is empty
   assign pend_data = pend_err ? '0 : mem_rdata;
   assign pend_ent  = {pend_last, (pend_err ? 2'b10 : 2'b00), pend_data};
   assign has_buf   = (occ != 2'd0);
   assign head      = has_buf ? b0 : pend_ent;
   assign s_rvalid  = has_buf | pend;
   assign s_rdata   = s_rvalid ? head[DATA_W-1:0] : '0;
   assign s_rresp   = s_rvalid ? head[DATA_W+1:DATA_W] : 2'b00;
   assign s_rlast   = s_rvalid & head[EW-1];

   assign r_hs      = s_rvalid & s_rready;
   assign buf_pop   = r_hs & has_buf;
   assign byp_pop   = r_hs & ~has_buf;
   assign push      = pend & ~byp_pop;
   assign wr_hi     = (occ - {1'b0, buf_pop}) != 2'd0;

   // Buffered + in-flight beats must fit in the two skid entries once this cycle's pop retires
   assign tot       = 3'(occ) + 3'(pend) + 3'(req);
   assign can_issue = (state == BURST) && (issued <= {1'b0, len}) && (tot < (3'd2 + 3'(r_hs)));

   always_ff @(posedge clk) begin
      if (buf_pop) b0 <= b1;
      if (push) begin
         if (wr_hi) b1 <= pend_ent;
         else       b0 <= pend_ent;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         s_arready <= 1'b1;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         waddr     <= '0;
         len       <= '0;
         burst     <= '0;
         err       <= 1'b0;
         issued    <= '0;
         req       <= 1'b0;
         req_last  <= 1'b0;
         pend      <= 1'b0;
         pend_last <= 1'b0;
         pend_err  <= 1'b0;
         occ       <= '0;
      end else begin
         req       <= 1'b0;
         mem_en    <= 1'b0;
         pend      <= req;
         pend_last <= req_last;
         pend_err  <= err;
         occ       <= 2'(occ - {1'b0, buf_pop} + {1'b0, push});
         case (state)
            IDLE: begin
               if (ar_hs) begin
                  len       <= s_arlen;
                  burst     <= s_arburst;
                  err       <= ar_err;
                  mem_addr  <= ar_wa;
                  mem_en    <= ~ar_err;
                  req       <= 1'b1;
                  req_last  <= (s_arlen == 8'd0);
                  waddr     <= next_addr(ar_wa, s_arburst, s_arlen);
                  issued    <= 9'd1;
                  state     <= BURST;
                  s_arready <= 1'b0;
               end
            end
            BURST: begin
               if (can_issue) begin
                  mem_addr <= waddr;
                  mem_en   <= ~err;
                  req      <= 1'b1;
                  req_last <= (issued == {1'b0, len});
                  waddr    <= next_addr(waddr, burst, len);
                  issued   <= issued + 9'd1;
               end
               if (r_hs && s_rlast) begin
                  state     <= IDLE;
                  s_arready <= 1'b1;
                  issued    <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_bram_rd_ctrl.sv
// Scoreboard bench for axi_bram_rd_ctrl: directed bursts push expected beats, a monitor pops them.
module tb_axi_bram_rd_ctrl;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MEM_AW = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] s_araddr;
   logic [7:0]        s_arlen;
   logic [2:0]        s_arsize;
   logic [1:0]        s_arburst;
   logic              s_arvalid;
   logic              s_arready;
   logic [DATA_W-1:0] s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rlast;
   logic              s_rvalid;
   logic              s_rready;
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_en;
   logic [DATA_W-1:0] mem_rdata;

   axi_bram_rd_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
      .clk(clk), .reset(reset),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
      .s_rready(s_rready),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        last;
      logic [1:0]  resp;
      logic [31:0] data;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    men_cnt = 0;
   int    rr_mode = 0;
   int    rphase = 0;
   int    hs_cyc = 0;
   int    first_rv_cyc = 0;
   bit    first_rv_seen = 1'b1;

   // BRAM model: word k holds k*0x11, one-cycle read latency
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= {20'b0, mem_addr} * 32'h11;
      cyc <= cyc + 1;
      if (mem_en) men_cnt <= men_cnt + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [1:0] r, input logic l);
      beat_t b;
      b.last = l;
      b.resp = r;
      b.data = d;
      exp_q.push_back(b);
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                          input logic [1:0] b);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      s_araddr  = a;
      s_arlen   = l;
      s_arsize  = sz;
      s_arburst = b;
      s_arvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (s_arready) begin
            hs_cyc = cyc;
            first_rv_seen = 1'b0;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL ar_timeout actual=arready_low required=arready_high");
      end
      @(posedge clk); #1;
      s_arvalid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #2;
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=%0d_beats_left required=0", name, exp_q.size());
         exp_q.delete();
      end
      chk({name, "_arready_after_last"}, 64'(s_arready), 64'd1);
   endtask

   // R-ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = held low
   initial begin
      s_rready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rr_mode)
            1: begin
               s_rready = (rphase == 0);
               rphase = (rphase + 1) % 3;
            end
            2: begin
               s_rready = 1'b0;
               rphase = 0;
            end
            default: begin
               s_rready = 1'b1;
               rphase = 0;
            end
         endcase
      end
   end

   // Monitor
   initial begin
      beat_t cur;
      beat_t prev;
      beat_t e;
      bit stalled;
      stalled = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (reset && s_rvalid) begin
            cur = {s_rlast, s_rresp, s_rdata};
            if (!first_rv_seen) begin
               first_rv_cyc = cyc;
               first_rv_seen = 1'b1;
            end
            chk("arready_low_in_burst", 64'(s_arready), 64'd0);
            if (stalled) chk("stable_while_stalled", 64'(cur), 64'(prev));
            if (s_rready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat actual=%h required=no_beat", cur);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", 64'(cur), 64'(e));
               end
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               prev = cur;
            end
         end else begin
            stalled = 1'b0;
         end
      end
   end

   initial begin
      int base;
      reset     = 1'b0;
      s_araddr  = '0;
      s_arlen   = '0;
      s_arsize  = '0;
      s_arburst = '0;
      s_arvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", 64'(s_arready), 64'd1);
      chk("rst_rvalid",  64'(s_rvalid),  64'd0);
      chk("rst_mem_en",  64'(mem_en),    64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_rdata",   64'(s_rdata),   64'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // INCR from word 4, streaming
      rr_mode = 0;
      push(32'h44, 2'b00, 1'b0); push(32'h55, 2'b00, 1'b0);
      push(32'h66, 2'b00, 1'b0); push(32'h77, 2'b00, 1'b1);
      send_ar(32'h10, 8'd3, 3'd2, 2'b01);
      wait_done("incr");
      chk("first_rvalid_latency", 64'(first_rv_cyc - hs_cyc), 64'd2);

      // Same burst with R backpressure
      rr_mode = 1;
      push(32'h44, 2'b00, 1'b0); push(32'h55, 2'b00, 1'b0);
      push(32'h66, 2'b00, 1'b0); push(32'h77, 2'b00, 1'b1);
      send_ar(32'h10, 8'd3, 3'd2, 2'b01);
      wait_done("incr_bp");
      rr_mode = 0;

      // FIXED at word 2
      push(32'h22, 2'b00, 1'b0); push(32'h22, 2'b00, 1'b0); push(32'h22, 2'b00, 1'b1);
      send_ar(32'h8, 8'd2, 3'd2, 2'b00);
      wait_done("fixed");

      // Bad size
      base = men_cnt;
      push(32'h0, 2'b10, 1'b0); push(32'h0, 2'b10, 1'b1);
      send_ar(32'h0, 8'd1, 3'd1, 2'b01);
      wait_done("bad_size");
      chk("bad_size_no_mem_en", 64'(men_cnt - base), 64'd0);

      // Out of range address
      base = men_cnt;
      push(32'h0, 2'b10, 1'b0); push(32'h0, 2'b10, 1'b1);
      send_ar(32'h4000, 8'd1, 3'd2, 2'b01);
      wait_done("bad_addr");
      chk("bad_addr_no_mem_en", 64'(men_cnt - base), 64'd0);

      // WRAP from word 6
`ifdef AXI_WRAP_BURST_EN
      push(32'h66, 2'b00, 1'b0); push(32'h77, 2'b00, 1'b0);
      push(32'h44, 2'b00, 1'b0); push(32'h55, 2'b00, 1'b1);
`else
      push(32'h0, 2'b10, 1'b0); push(32'h0, 2'b10, 1'b0);
      push(32'h0, 2'b10, 1'b0); push(32'h0, 2'b10, 1'b1);
`endif
      send_ar(32'h18, 8'd3, 3'd2, 2'b10);
      wait_done("wrap");

      // Unaligned single beat
      push(32'h44, 2'b00, 1'b1);
      send_ar(32'h13, 8'd0, 3'd2, 2'b01);
      wait_done("unaligned");

      // Buffer full with rready held low: only two reads may issue
      rr_mode = 2;
      base = men_cnt;
      push(32'h88, 2'b00, 1'b0); push(32'h99, 2'b00, 1'b0);
      push(32'hAA, 2'b00, 1'b0); push(32'hBB, 2'b00, 1'b1);
      send_ar(32'h20, 8'd3, 3'd2, 2'b01);
      repeat (6) @(posedge clk);
      #2;
      chk("stall_reads_issued", 64'(men_cnt - base), 64'd2);
      rr_mode = 0;
      wait_done("stall");

      // Reset in the middle of an 8-beat burst
      for (int i = 0; i < 8; i++) push(32'(i * 32'h11), 2'b00, (i == 7));
      send_ar(32'h0, 8'd7, 3'd2, 2'b01);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #2;
         if (exp_q.size() <= 5) break;
      end
      chk("midburst_beats_left", 64'(exp_q.size()), 64'd5);
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_arready", 64'(s_arready), 64'd1);
      chk("mid_rst_rvalid",  64'(s_rvalid),  64'd0);
      chk("mid_rst_rlast",   64'(s_rlast),   64'd0);
      chk("mid_rst_rresp",   64'(s_rresp),   64'd0);
      chk("mid_rst_rdata",   64'(s_rdata),   64'd0);
      chk("mid_rst_mem_en",  64'(mem_en),    64'd0);
      chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      push(32'h0, 2'b00, 1'b1);
      send_ar(32'h0, 8'd0, 3'd2, 2'b01);
      wait_done("after_reset");

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
